// File: rtl/nn_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nn_reset_sequencer
// Purpose  : Power-on / software reset generator with staged, ascending
//            per-channel release of active-low reset outputs.
// Revision : 1.0 - initial release
// ============================================================================
module nn_reset_sequencer #(
    parameter int NUM_CHANNELS         = 4,
    parameter int INITIAL_RESET_CYCLES = 5,
    parameter int SW_RESET_CYCLES      = 3,
    parameter int STAGE_GAP_CYCLES     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sw_req,
    input  logic [NUM_CHANNELS-1:0] sw_mask,
    output logic                    sw_ack,
    output logic [NUM_CHANNELS-1:0] reset_out,
    output logic                    all_released,
    output logic                    busy
);

    localparam int c_MAX_A   = (INITIAL_RESET_CYCLES > SW_RESET_CYCLES) ?
                               INITIAL_RESET_CYCLES : SW_RESET_CYCLES;
    localparam int c_MAX_CYC = (c_MAX_A > STAGE_GAP_CYCLES) ? c_MAX_A : STAGE_GAP_CYCLES;
    localparam int c_CW      = $clog2(c_MAX_CYC + 1);

    localparam logic [c_CW-1:0] c_INIT_LAST = c_CW'(INITIAL_RESET_CYCLES - 1);
    localparam logic [c_CW-1:0] c_SW_LAST   = c_CW'(SW_RESET_CYCLES - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST  = c_CW'(STAGE_GAP_CYCLES - 1);
    localparam logic [c_CW-1:0] c_CNT_MAX   = '1;
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);

    localparam logic [NUM_CHANNELS-1:0] c_CH_ONE = NUM_CHANNELS'(1);

    localparam logic [1:0] c_ST_HOLD    = 2'd0;
    localparam logic [1:0] c_ST_RELEASE = 2'd1;
    localparam logic [1:0] c_ST_RUN     = 2'd2;
    localparam logic [1:0] c_ST_SW_HOLD = 2'd3;

    logic                    r_sync1;
    logic                    r_sync2;
    logic [1:0]              r_state;
    logic [c_CW-1:0]         r_cnt;
    logic [NUM_CHANNELS-1:0] r_pending;

    logic [NUM_CHANNELS-1:0] w_lowest;
    logic [NUM_CHANNELS-1:0] w_remaining;
    logic                    w_release_now;
    logic                    w_counting;
    logic                    w_accept;

    // Two's-complement trick isolates the lowest set pending bit.
    always_comb begin
        w_lowest    = r_pending & ((~r_pending) + c_CH_ONE);
        w_remaining = r_pending & ~w_lowest;
        w_release_now = 1'b0;
        w_counting    = 1'b0;
        case (r_state)
            c_ST_HOLD: begin
                w_release_now = r_sync2 && (r_cnt == c_INIT_LAST);
                w_counting    = r_sync2;
            end
            c_ST_RELEASE: begin
                w_release_now = (r_cnt == c_GAP_LAST);
                w_counting    = 1'b1;
            end
            c_ST_SW_HOLD: begin
                w_release_now = (r_cnt == c_SW_LAST);
                w_counting    = 1'b1;
            end
            default: begin
                w_release_now = 1'b0;
                w_counting    = 1'b0;
            end
        endcase
        w_accept = (r_state == c_ST_RUN) && sw_req && (sw_mask != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= 1'b1;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_HOLD;
            r_cnt        <= '0;
            r_pending    <= '1;
            reset_out    <= '0;
            sw_ack       <= 1'b0;
            all_released <= 1'b0;
            busy         <= 1'b1;
        end else begin
            sw_ack <= 1'b0;
            if (w_release_now) begin
                reset_out <= reset_out | w_lowest;
                r_pending <= w_remaining;
                r_cnt     <= '0;
                // The final release and the entry into RUN share one edge.
                if (w_remaining == '0) begin
                    r_state      <= c_ST_RUN;
                    all_released <= 1'b1;
                    busy         <= 1'b0;
                end else begin
                    r_state <= c_ST_RELEASE;
                end
            end else if (w_accept) begin
                r_pending    <= sw_mask;
                reset_out    <= reset_out & ~sw_mask;
                sw_ack       <= 1'b1;
                r_cnt        <= '0;
                r_state      <= c_ST_SW_HOLD;
                all_released <= 1'b0;
                busy         <= 1'b1;
            end else if (w_counting && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_reset_sequencer.sv
`default_nettype none
// Directed testbench for nn_reset_sequencer: default 4-channel instance and
// a single-channel instance with all cycle parameters at their minimum.
module tb_nn_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sw_req = 1'b0;
    logic [3:0] sw_mask = 4'b0000;
    logic       sw_ack;
    logic [3:0] reset_out;
    logic       all_released;
    logic       busy;

    logic       reset1 = 1'b0;
    logic       sw_req1 = 1'b0;
    logic [0:0] sw_mask1 = 1'b0;
    logic       sw_ack1;
    logic [0:0] reset_out1;
    logic       all_released1;
    logic       busy1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nn_reset_sequencer #(
        .NUM_CHANNELS(4), .INITIAL_RESET_CYCLES(5),
        .SW_RESET_CYCLES(3), .STAGE_GAP_CYCLES(2)
    ) u_dut (
        .clk(clk), .reset(reset), .sw_req(sw_req), .sw_mask(sw_mask),
        .sw_ack(sw_ack), .reset_out(reset_out),
        .all_released(all_released), .busy(busy)
    );

    nn_reset_sequencer #(
        .NUM_CHANNELS(1), .INITIAL_RESET_CYCLES(1),
        .SW_RESET_CYCLES(1), .STAGE_GAP_CYCLES(1)
    ) u_dut1 (
        .clk(clk), .reset(reset1), .sw_req(sw_req1), .sw_mask(sw_mask1),
        .sw_ack(sw_ack1), .reset_out(reset_out1),
        .all_released(all_released1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset values, sampled with no clock edge in between.
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (reset_out !== 4'b0000 || sw_ack !== 1'b0 || all_released !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: out=%b ack=%b all=%b busy=%b, required out=0000 ack=0 all=0 busy=1",
                     reset_out, sw_ack, all_released, busy);
        end
    endtask

    // Raise reset before E1 and check every edge E1..E13 against the release schedule.
    task automatic test_power_on(input bit hold_req);
        logic [3:0] exp_out;
        @(negedge clk);
        reset = 1'b1;
        if (hold_req) begin
            sw_req  = 1'b1;
            sw_mask = 4'b1111;
        end
        for (int e = 1; e <= 13; e++) begin
            tick();
            exp_out = 4'b0000;
            for (int k = 0; k < 4; k++)
                if (e >= 7 + 2 * k) exp_out[k] = 1'b1;
            checks++;
            if (reset_out !== exp_out || sw_ack !== 1'b0 ||
                all_released !== (e >= 13) || busy !== (e < 13)) begin
                errors++;
                $display("FAIL power_on E%0d: out=%b ack=%b all=%b busy=%b, required out=%b ack=0 all=%b busy=%b",
                         e, reset_out, sw_ack, all_released, busy, exp_out, (e >= 13), (e < 13));
            end
            if (hold_req && e == 5) begin
                sw_req  = 1'b0;
                sw_mask = 4'b0000;
            end
        end
    endtask

    // Subset request 1010 accepted at T; optional ignored request at T+1.
    task automatic test_sw_subset(input bit second_req, input int stop_at);
        logic [3:0] exp_out;
        sw_req  = 1'b1;
        sw_mask = 4'b1010;
        tick();
        sw_req  = 1'b0;
        sw_mask = 4'b0000;
        checks++;
        if (reset_out !== 4'b0101 || sw_ack !== 1'b1 || all_released !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sw_accept T: out=%b ack=%b all=%b busy=%b, required out=0101 ack=1 all=0 busy=1",
                     reset_out, sw_ack, all_released, busy);
        end
        if (second_req) begin
            sw_req  = 1'b1;
            sw_mask = 4'b0001;
        end
        for (int t = 1; t <= stop_at; t++) begin
            tick();
            if (t == 1) begin
                sw_req  = 1'b0;
                sw_mask = 4'b0000;
            end
            exp_out = 4'b0101;
            if (t >= 3) exp_out[1] = 1'b1;
            if (t >= 5) exp_out[3] = 1'b1;
            checks++;
            if (reset_out !== exp_out || sw_ack !== 1'b0 ||
                all_released !== (t >= 5) || busy !== (t < 5)) begin
                errors++;
                $display("FAIL sw_seq T+%0d: out=%b ack=%b all=%b busy=%b, required out=%b ack=0 all=%b busy=%b",
                         t, reset_out, sw_ack, all_released, busy, exp_out, (t >= 5), (t < 5));
            end
        end
    endtask

    task automatic test_ignored();
        test_reset();
        test_power_on(1'b1);
        sw_req  = 1'b1;
        sw_mask = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (sw_ack !== 1'b0 || reset_out !== 4'b1111 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ignored_zero_mask %0d: ack=%b out=%b busy=%b, required ack=0 out=1111 busy=0",
                         i, sw_ack, reset_out, busy);
            end
        end
        sw_req = 1'b0;
    endtask

    task automatic test_reset_mid_sequence();
        test_sw_subset(1'b0, 3);
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (reset_out !== 4'b0000 || busy !== 1'b1 || all_released !== 1'b0 || sw_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: out=%b busy=%b all=%b ack=%b, required out=0000 busy=1 all=0 ack=0",
                     reset_out, busy, all_released, sw_ack);
        end
        tick();
        test_power_on(1'b0);
    endtask

    task automatic test_single_channel();
        @(negedge clk);
        reset1 = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (reset_out1 !== (e >= 3) || all_released1 !== (e >= 3) || busy1 !== (e < 3)) begin
                errors++;
                $display("FAIL single_power_on E%0d: out=%b all=%b busy=%b, required out=%b all=%b busy=%b",
                         e, reset_out1, all_released1, busy1, (e >= 3), (e >= 3), (e < 3));
            end
        end
        sw_req1  = 1'b1;
        sw_mask1 = 1'b1;
        tick();
        sw_req1  = 1'b0;
        sw_mask1 = 1'b0;
        checks++;
        if (reset_out1 !== 1'b0 || sw_ack1 !== 1'b1 || busy1 !== 1'b1 || all_released1 !== 1'b0) begin
            errors++;
            $display("FAIL single_sw T: out=%b ack=%b busy=%b all=%b, required out=0 ack=1 busy=1 all=0",
                     reset_out1, sw_ack1, busy1, all_released1);
        end
        tick();
        checks++;
        if (reset_out1 !== 1'b1 || sw_ack1 !== 1'b0 || busy1 !== 1'b0 || all_released1 !== 1'b1) begin
            errors++;
            $display("FAIL single_sw T+1: out=%b ack=%b busy=%b all=%b, required out=1 ack=0 busy=0 all=1",
                     reset_out1, sw_ack1, busy1, all_released1);
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_power_on(1'b0);
        tick();
        test_sw_subset(1'b0, 6);
        test_sw_subset(1'b1, 6);
        test_ignored();
        test_reset_mid_sequence();
        test_single_channel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
